bm_dir_ctrl: RTL



---
 rtl/bm_pkg.sv | 22 ++
 rtl/btn_debounce.sv | 39 +++
 rtl/bm_dir_ctrl.sv | 69 ++++++
 3 files changed

// File: rtl/bm_pkg.sv
// bm_pkg: direction encodings and arbitration helpers shared by the
// direction controller and the sprite/motion module.
//   CD_U/CD_R/CD_D/CD_L : 2-bit current-direction codes
//   CD_RESET            : direction faced after reset (down)
//   pick                : one-hot highest-priority set bit of {U,R,D,L}
//   dir_code            : one-hot {U,R,D,L} to 2-bit direction code
package bm_pkg;
    localparam logic [1:0] CD_U = 2'b00;
    localparam logic [1:0] CD_R = 2'b01;
    localparam logic [1:0] CD_D = 2'b10;
    localparam logic [1:0] CD_L = 2'b11;
    localparam logic [1:0] CD_RESET = CD_D;

    // Priority U > R > D > L, bit order {U,R,D,L}
    function automatic logic [3:0] pick(input logic [3:0] v);
        return v[3] ? 4'b1000 : v[2] ? 4'b0100 : v[1] ? 4'b0010 : v[0] ? 4'b0001 : 4'b0000;
    endfunction

    function automatic logic [1:0] dir_code(input logic [3:0] v);
        return v[3] ? CD_U : v[2] ? CD_R : v[1] ? CD_D : CD_L;
    endfunction
endpackage

// File: rtl/btn_debounce.sv
// btn_debounce: 2-FF synchronizer followed by a counting debouncer.
//   clk, reset_n : clock, asynchronous active-low reset
//   btn          : raw asynchronous button
//   stable       : debounced level
module btn_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20
) (
    input  logic clk,
    input  logic reset_n,
    input  logic btn,
    output logic stable
);
    localparam logic [CNT_W-1:0] LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic sync1, sync2;
    logic [CNT_W-1:0] cnt;

    // Any return to the stable level discards the partial count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            sync1  <= 1'b0;
            sync2  <= 1'b0;
            stable <= 1'b0;
            cnt    <= '0;
        end else begin
            sync1 <= btn;
            sync2 <= sync1;
            if (sync2 == stable) begin
                cnt <= '0;
            end else if (cnt == LAST) begin
                stable <= sync2;
                cnt    <= '0;
            end else begin
                cnt <= cnt + 1'b1;
            end
        end
    end
endmodule

// File: rtl/bm_dir_ctrl.sv
// bm_dir_ctrl: debounces the d-pad and resolves it into one active direction.
//   clk, reset_n                 : clock, asynchronous active-low reset
//   btn_l, btn_r, btn_u, btn_d   : raw active-high buttons
//   gameover                     : freezes player control
//   L, R, U, D                   : registered one-hot active direction
//   cd                           : current direction code (held when idle)
//   moving                       : OR of L/R/U/D, registered
module bm_dir_ctrl
    import bm_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int CNT_W = 20
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       btn_l,
    input  logic       btn_r,
    input  logic       btn_u,
    input  logic       btn_d,
    input  logic       gameover,
    output logic       L,
    output logic       R,
    output logic       U,
    output logic       D,
    output logic [1:0] cd,
    output logic       moving
);
    // All 4-bit vectors are ordered {U,R,D,L} to match the priority order.
    logic [3:0] raw, held, prev, press, cur, nxt;

    assign raw = {btn_u, btn_r, btn_d, btn_l};

    for (genvar g = 0; g < 4; g++) begin : g_db
        btn_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .CNT_W(CNT_W)
        ) u_db (
            .clk(clk),
            .reset_n(reset_n),
            .btn(raw[g]),
            .stable(held[g])
        );
    end

    assign press = held & ~prev;
    assign cur   = {U, R, D, L};

    // A fresh press beats a held direction; otherwise keep the current one
    // while held, else fall back to the highest-priority held button.
    always_comb begin
        nxt = gameover ? 4'b0000 :
              |press ? pick(press) :
              |(cur & held) ? cur : pick(held);
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            prev         <= 4'b0000;
            {U, R, D, L} <= 4'b0000;
            moving       <= 1'b0;
            cd           <= CD_RESET;
        end else begin
            prev         <= held;
            {U, R, D, L} <= nxt;
            moving       <= |nxt;
            if (|nxt) cd <= dir_code(nxt);
        end
    end
endmodule
